mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised memory-mapped I/O bridge between the processor's data-memory port, the DMEM, the PS/2 keyboard and the VGA renderer. It decodes `address_dmem`, returns DMEM data or MMIO register data to the processor, and keeps MMIO stores out of DMEM. It holds position and velocity registers for `NUM_PLAYERS` characters and a scan-code FIFO fed by the keyboard. It replaces the single-player, single-scan-code address decoding that previously sat in the skeleton.

## Interface
- `NUM_PLAYERS`, 4: player channels, 1..16.
- `KEY_FIFO_DEPTH`, 8: scan-code FIFO entries, power of two, 2..64.
- `KBD_ADDR`, 4100: keyboard data word.
- `KBD_STAT_ADDR`, 4101: keyboard status word.
- `PLAYER_BASE`, 4200: first player word.
- `INIT_X`, 240; `INIT_Y`, 240: player position reset values.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `address_dmem` in 12: processor data address.
- `proc_data_out` in 32: processor store data.
- `wren` in 1: processor store enable.
- `dmem_q` in 32: DMEM read data, port A.
- `dmem_wren` out 1: DMEM port-A write enable, equal to `wren & ~mmio_hit`.
- `proc_data_in` out 32: load data returned to the processor.
- `ps2_key_pressed` in 1: keyboard strobe, level.
- `ps2_out` in 8: keyboard scan code.
- `vga_player_sel` in 4: player index for the renderer.
- `vga_player_x`, `vga_player_y` out 32: position of the selected player, combinational.

## Operation
- `mmio_hit` is set for `KBD_ADDR`, `KBD_STAT_ADDR`, and `PLAYER_BASE .. PLAYER_BASE+4*NUM_PLAYERS-1`.
- Player word map:
  - Player i, offset 0: x.
  - Player i, offset 1: y.
  - Player i, offset 2: vel (signed).
  - Player i, offset 3: reserved; reads 0, writes ignored.
- Read mux: `proc_data_in` is combinational.
  - On an MMIO hit it returns the selected register.
  - Otherwise it returns `dmem_q`.
  - No tri-states are used.
- Player registers:
  - A store with `wren` at a player word updates that word at the rising edge.
  - Reset values: x=`INIT_X`, y=`INIT_Y`, vel=0.
- Keyboard capture:
  - `ps2_key_pressed` is registered into `kp_q`.
  - A push happens at the edge where `ps2_key_pressed & ~kp_q`. `ps2_out` is sampled at that edge.
- Keyboard data read at `KBD_ADDR` returns `{23'b0, !empty, head}`. `head` is 0 when the FIFO is empty.
- Pop: any store to `KBD_ADDR` pops one entry. A store to an empty FIFO is ignored.
- Status read at `KBD_STAT_ADDR` returns `{24'b0, count[6:0], overflow}`.
- Status write: any store to `KBD_STAT_ADDR` clears `overflow`.
- FIFO boundary rules:
  - Push while full, no pop: the code is dropped and `overflow` is set (sticky).
  - Push and pop in the same cycle while full: both succeed, `count` is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored; `count`=1.
  - Read and write pointers wrap modulo `KEY_FIFO_DEPTH`.
- Out-of-range `vga_player_sel` (>= `NUM_PLAYERS`) returns x=y=0.

## Timing
- Loads are combinational from `address_dmem`, with zero added latency over DMEM.
- Stores take effect at the next rising edge.
  - A load issued in the same cycle as a store to the same word returns the old value.
- A keyboard push becomes visible on the cycle after the capturing edge.
- `reset`, including mid-operation:
  - Pointers, `count`, `overflow` and `kp_q` clear to 0.
  - Players return to their initial values.
  - Stores in the reset cycle are discarded.
  - `dmem_wren` stays combinational and is not gated by reset.
- Reset values of outputs:
  - `proc_data_in`: follows the mux.
  - KBD read: 0.
  - Status read: 0.

## Configuration
- `MMIO_KBD_FIFO_EN` defined: the FIFO behaviour above applies.
- `MMIO_KBD_FIFO_EN` undefined:
  - A single 8-bit register latches the last scan code on each rising edge of the strobe. It resets to 0.
  - A `KBD_ADDR` read returns `{24'b0, code}` with no valid bit.
  - Stores to `KBD_ADDR` are ignored.
  - `KBD_STAT_ADDR` reads 0.
  - `KEY_FIFO_DEPTH` is unused.

## Test plan
- Reset, then read 4200, 4201, 4202, 4203 -> 240, 240, 0, 0; `dmem_wren`=0 for stores to 4200.
- Store 0x55 to word 4209 (player 2, y), then read it -> 0x55; `vga_player_sel`=2 gives `vga_player_y`=0x55; `dmem_wren` is 0 during that store.
- Push codes 0x1C, 0x23, 0x1D -> read 4100 gives 0x11C and status gives 0x06. Store to 4100 -> read gives 0x123.
- Depth 8: push 9 codes -> status gives 0x11 (count 8, overflow). Store to 4101 -> 0x10. Push and pop in the same cycle -> count stays 8, overflow stays 0.
- Hold `ps2_key_pressed` high for 5 cycles -> exactly one push.
- Assert `reset` while the FIFO holds 3 codes -> the next read of 4100 gives 0.
- Non-MMIO address 100 with `dmem_q`=0xDEADBEEF -> `proc_data_in`=0xDEADBEEF and `dmem_wren` follows `wren`.

Source files
------------

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_bridge
//  Purpose  : Memory-mapped I/O bridge between the processor data port, DMEM,
//             the PS/2 keyboard and the VGA renderer. Decodes address_dmem,
//             steers loads from DMEM or MMIO registers, keeps MMIO stores out
//             of DMEM, holds x/y/vel registers for NUM_PLAYERS characters and
//             captures keyboard scan codes.
//  Config   : MMIO_KBD_FIFO_EN defined   -> scan codes queue in a FIFO of
//                                           KEY_FIFO_DEPTH entries with a
//                                           status word (count, overflow).
//             MMIO_KBD_FIFO_EN undefined -> a single register holds the most
//                                           recent scan code.
//  Ports    : clock, reset          - clock (rising edge), sync active-high reset
//             address_dmem[11:0]    - processor data address
//             proc_data_out[31:0]   - processor store data
//             wren                  - processor store enable
//             dmem_q[31:0]          - DMEM port-A read data
//             dmem_wren             - DMEM port-A write enable (non-MMIO stores)
//             proc_data_in[31:0]    - load data returned to the processor
//             ps2_key_pressed       - keyboard strobe (level)
//             ps2_out[7:0]          - keyboard scan code
//             vga_player_sel[3:0]   - player index requested by the renderer
//             vga_player_x/_y[31:0] - position of the selected player
//  Revision : 1.0 - initial multi-player / scan-code FIFO release
// ============================================================================
module mmio_bridge #(
   parameter int NUM_PLAYERS    = 4,
   parameter int KEY_FIFO_DEPTH = 8,
   parameter int KBD_ADDR       = 4100,
   parameter int KBD_STAT_ADDR  = 4101,
   parameter int PLAYER_BASE    = 4200,
   parameter int INIT_X         = 240,
   parameter int INIT_Y         = 240
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] proc_data_out,
   input  logic        wren,
   input  logic [31:0] dmem_q,
   output logic        dmem_wren,
   output logic [31:0] proc_data_in,
   input  logic        ps2_key_pressed,
   input  logic [7:0]  ps2_out,
   input  logic [3:0]  vga_player_sel,
   output logic [31:0] vga_player_x,
   output logic [31:0] vga_player_y
);

   // The processor address bus is 12 bits wide, so the word addresses are
   // matched modulo 4096 (e.g. 4100 decodes as 4, 4200 as 104).
   localparam logic [11:0] C_KBD_A   = 12'(KBD_ADDR);
   localparam logic [11:0] C_STAT_A  = 12'(KBD_STAT_ADDR);
   localparam logic [11:0] C_PL_BASE = 12'(PLAYER_BASE);
   localparam logic [11:0] C_PL_SPAN = 12'(4 * NUM_PLAYERS);

   // ---------------------------------------------------------------- decode
   logic        w_kbd_sel;
   logic        w_stat_sel;
   logic        w_pl_hit;
   logic        w_mmio_hit;
   logic [11:0] w_pl_off;
   logic [3:0]  w_pl_idx;
   logic [1:0]  w_pl_word;
   logic [31:0] w_pl_rd;
   logic [31:0] w_kbd_rd;
   logic [31:0] w_stat_rd;
   logic        w_unused;

   assign w_kbd_sel  = (address_dmem == C_KBD_A);
   assign w_stat_sel = (address_dmem == C_STAT_A);
   // Unsigned wrap makes addresses below the base land far outside the span.
   assign w_pl_off   = address_dmem - C_PL_BASE;
   assign w_pl_hit   = (w_pl_off < C_PL_SPAN);
   assign w_pl_idx   = w_pl_off[5:2];
   assign w_pl_word  = w_pl_off[1:0];
   assign w_mmio_hit = w_kbd_sel | w_stat_sel | w_pl_hit;

   assign dmem_wren  = wren & ~w_mmio_hit;

   assign w_unused   = ^{w_pl_off[11:6], 32'(KEY_FIFO_DEPTH)};

   // ------------------------------------------------------- player registers
   logic [31:0] x_q   [NUM_PLAYERS];
   logic [31:0] y_q   [NUM_PLAYERS];
   logic [31:0] vel_q [NUM_PLAYERS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            x_q[i]   <= 32'(INIT_X);
            y_q[i]   <= 32'(INIT_Y);
            vel_q[i] <= '0;
         end
      end else if (wren && w_pl_hit) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_pl_idx == 4'(i)) begin
               case (w_pl_word)
                  2'd0:    x_q[i]   <= proc_data_out;
                  2'd1:    y_q[i]   <= proc_data_out;
                  2'd2:    vel_q[i] <= proc_data_out;
                  default: ; // reserved word, writes dropped
               endcase
            end
         end
      end
   end

   always_comb begin
      w_pl_rd = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (w_pl_idx == 4'(i)) begin
            case (w_pl_word)
               2'd0:    w_pl_rd = x_q[i];
               2'd1:    w_pl_rd = y_q[i];
               2'd2:    w_pl_rd = vel_q[i];
               default: w_pl_rd = '0;
            endcase
         end
      end
   end

   always_comb begin
      vga_player_x = '0;
      vga_player_y = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (vga_player_sel == 4'(i)) begin
            vga_player_x = x_q[i];
            vga_player_y = y_q[i];
         end
      end
   end

   // ------------------------------------------------------ keyboard capture
`ifdef MMIO_KBD_FIFO_EN
   localparam int PW = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;

   logic [7:0]    fifo_q [KEY_FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [6:0]    count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          kp_q;
   logic          w_push_req;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;

   assign w_push_req = ps2_key_pressed & ~kp_q;
   assign w_empty    = (count_q == 7'd0);
   assign w_full     = (count_q == 7'(KEY_FIFO_DEPTH));
   assign w_pop      = wren & w_kbd_sel & ~w_empty;
   // A pop in the same cycle frees the head slot, so a full FIFO still
   // accepts the push.
   assign w_push     = w_push_req & (~w_full | w_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 7'd1;
         2'b01:   count_d = count_q - 7'd1;
         default: ;
      endcase
      // A dropped code in the clearing cycle still leaves overflow set.
      if (wren && w_stat_sel)    ovf_d = 1'b0;
      if (w_push_req && !w_push) ovf_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         kp_q     <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         kp_q     <= ps2_key_pressed;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         fifo_q[wr_ptr_q] <= ps2_out;
      end
   end

   assign w_kbd_rd  = {23'b0, ~w_empty, (w_empty ? 8'h00 : fifo_q[rd_ptr_q])};
   assign w_stat_rd = {24'b0, count_q, ovf_q};
`else
   logic [7:0] code_q;
   logic       kp_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         code_q <= '0;
         kp_q   <= 1'b0;
      end else begin
         kp_q <= ps2_key_pressed;
         if (ps2_key_pressed && !kp_q) begin
            code_q <= ps2_out;
         end
      end
   end

   assign w_kbd_rd  = {24'b0, code_q};
   assign w_stat_rd = '0;
`endif

   // ------------------------------------------------------------- read mux
   always_comb begin
      proc_data_in = dmem_q;
      if (w_kbd_sel)       proc_data_in = w_kbd_rd;
      else if (w_stat_sel) proc_data_in = w_stat_rd;
      else if (w_pl_hit)   proc_data_in = w_pl_rd;
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_bridge
//  Purpose  : Self-checking bench for mmio_bridge. Directed scenarios plus a
//             randomized run compared against a behavioural model (player
//             arrays and a scan-code queue). Keyboard checks follow the build
//             selected by MMIO_KBD_FIFO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;
   localparam int NP    = 4;
   localparam int DEPTH = 8;
   localparam int KBD   = 4100;
   localparam int STAT  = 4101;
   localparam int PBASE = 4200;
   localparam int IX    = 240;
   localparam int IY    = 240;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] proc_data_out;
   logic        wren;
   logic [31:0] dmem_q;
   logic        dmem_wren;
   logic [31:0] proc_data_in;
   logic        ps2_key_pressed;
   logic [7:0]  ps2_out;
   logic [3:0]  vga_player_sel;
   logic [31:0] vga_player_x;
   logic [31:0] vga_player_y;

   always #5 clock = ~clock;

   mmio_bridge #(
      .NUM_PLAYERS(NP), .KEY_FIFO_DEPTH(DEPTH), .KBD_ADDR(KBD),
      .KBD_STAT_ADDR(STAT), .PLAYER_BASE(PBASE), .INIT_X(IX), .INIT_Y(IY)
   ) dut (
      .clock(clock), .reset(reset), .address_dmem(address_dmem),
      .proc_data_out(proc_data_out), .wren(wren), .dmem_q(dmem_q),
      .dmem_wren(dmem_wren), .proc_data_in(proc_data_in),
      .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
      .vga_player_sel(vga_player_sel), .vga_player_x(vga_player_x),
      .vga_player_y(vga_player_y)
   );

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------ model
   logic [31:0] m_x [NP];
   logic [31:0] m_y [NP];
   logic [31:0] m_v [NP];
   logic [7:0]  m_q [$];
   logic        m_ovf;
   logic        m_kp;
   logic [7:0]  m_code;

   logic [31:0] obs_rd, exp_rd;
   logic        obs_wren, exp_wren;

   function automatic logic [11:0] a12(input int a);
      return 12'(a % 4096);
   endfunction

   function automatic bit is_mmio(input logic [11:0] a);
      int off;
      off = int'(a) - (PBASE % 4096);
      return (int'(a) == KBD % 4096) || (int'(a) == STAT % 4096) ||
             (off >= 0 && off < 4 * NP);
   endfunction

   function automatic logic [31:0] exp_read(input logic [11:0] a);
      int off;
      off = int'(a) - (PBASE % 4096);
      if (int'(a) == KBD % 4096) begin
`ifdef MMIO_KBD_FIFO_EN
         if (m_q.size() > 0) return {23'b0, 1'b1, m_q[0]};
         return 32'd0;
`else
         return {24'b0, m_code};
`endif
      end
      if (int'(a) == STAT % 4096) begin
`ifdef MMIO_KBD_FIFO_EN
         return {24'b0, 7'(m_q.size()), m_ovf};
`else
         return 32'd0;
`endif
      end
      if (off >= 0 && off < 4 * NP) begin
         case (off % 4)
            0:       return m_x[off / 4];
            1:       return m_y[off / 4];
            2:       return m_v[off / 4];
            default: return 32'd0;
         endcase
      end
      return dmem_q;
   endfunction

   task automatic model_update(input logic rst, input logic [11:0] a, input logic we,
                               input logic [31:0] wd, input logic kp, input logic [7:0] code);
      int off;
      bit push_req;
`ifdef MMIO_KBD_FIFO_EN
      int orig;
      bit pop_req;
`endif
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            m_x[i] = IX; m_y[i] = IY; m_v[i] = 0;
         end
         m_q.delete();
         m_ovf = 0; m_kp = 0; m_code = 0;
         return;
      end
      push_req = kp && !m_kp;
      m_kp = kp;
      off = int'(a) - (PBASE % 4096);
      if (we && off >= 0 && off < 4 * NP) begin
         case (off % 4)
            0: m_x[off / 4] = wd;
            1: m_y[off / 4] = wd;
            2: m_v[off / 4] = wd;
            default: ;
         endcase
      end
`ifdef MMIO_KBD_FIFO_EN
      pop_req = we && (int'(a) == KBD % 4096);
      orig = m_q.size();
      if (pop_req && orig > 0) void'(m_q.pop_front());
      if (we && int'(a) == STAT % 4096) m_ovf = 0;
      if (push_req) begin
         if (orig < DEPTH || (pop_req && orig > 0)) m_q.push_back(code);
         else m_ovf = 1;
      end
`else
      if (push_req) m_code = code;
`endif
   endtask

   // One clock cycle: drive at negedge, sample 1 time unit later, advance model.
   task automatic step(input logic rst, input int addr, input logic we, input logic [31:0] wd,
                       input logic kp, input logic [7:0] code, input logic [31:0] dq);
      @(negedge clock);
      reset = rst; address_dmem = a12(addr); wren = we; proc_data_out = wd;
      ps2_key_pressed = kp; ps2_out = code; dmem_q = dq;
      #1;
      obs_rd   = proc_data_in;
      obs_wren = dmem_wren;
      exp_rd   = exp_read(a12(addr));
      exp_wren = we & ~is_mmio(a12(addr));
      model_update(rst, a12(addr), we, wd, kp, code);
   endtask

   task automatic push_code(input logic [7:0] c);
      step(0, 0, 0, 0, 1, c, 0);
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset;
      logic [31:0] want [4];
      want = '{32'd240, 32'd240, 32'd0, 32'd0};
      step(1, PBASE, 1, 32'h99, 0, 0, 0);
      checks++;
      if (obs_wren !== 1'b0) begin
         errors++; $display("FAIL reset_dmem_wren: got %b expected 0", obs_wren);
      end
      step(1, PBASE, 1, 32'h99, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, PBASE + i, 0, 0, 0, 0, 32'hFFFF_FFFF);
         checks++;
         if (obs_rd !== want[i]) begin
            errors++; $display("FAIL reset_read_%0d: got %h expected %h", PBASE + i, obs_rd, want[i]);
         end
      end
      step(0, KBD, 0, 0, 0, 0, 32'hFFFF_FFFF);
      checks++;
      if (obs_rd !== 32'd0) begin
         errors++; $display("FAIL reset_kbd: got %h expected 0", obs_rd);
      end
      step(0, STAT, 0, 0, 0, 0, 32'hFFFF_FFFF);
      checks++;
      if (obs_rd !== 32'd0) begin
         errors++; $display("FAIL reset_stat: got %h expected 0", obs_rd);
      end
   endtask

   task automatic test_player_store;
      step(0, 4209, 1, 32'h55, 0, 0, 32'h1234);
      checks++;
      if (obs_wren !== 1'b0) begin
         errors++; $display("FAIL player_store_wren: got %b expected 0", obs_wren);
      end
      step(0, 4209, 0, 0, 0, 0, 32'h1234);
      checks++;
      if (obs_rd !== 32'h55) begin
         errors++; $display("FAIL player_store_read: got %h expected 00000055", obs_rd);
      end
      vga_player_sel = 4'd2; #1;
      checks++;
      if (vga_player_y !== 32'h55 || vga_player_x !== 32'd240) begin
         errors++; $display("FAIL vga_sel2: got x=%h y=%h expected x=000000f0 y=00000055",
                            vga_player_x, vga_player_y);
      end
      vga_player_sel = 4'd7; #1;
      checks++;
      if (vga_player_x !== 32'd0 || vga_player_y !== 32'd0) begin
         errors++; $display("FAIL vga_out_of_range: got x=%h y=%h expected 0", vga_player_x, vga_player_y);
      end
      vga_player_sel = 4'd0;
   endtask

   task automatic test_same_cycle_rw;
      step(0, PBASE + 2, 1, 32'hFFFF_FFFD, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'd0) begin
         errors++; $display("FAIL same_cycle_old_value: got %h expected 0", obs_rd);
      end
      step(0, PBASE + 2, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'hFFFF_FFFD) begin
         errors++; $display("FAIL vel_signed_store: got %h expected fffffffd", obs_rd);
      end
      step(0, PBASE + 3, 1, 32'hABCD, 0, 0, 0);
      step(0, PBASE + 3, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'd0) begin
         errors++; $display("FAIL reserved_word: got %h expected 0", obs_rd);
      end
   endtask

   task automatic test_dmem_passthrough;
      step(0, 100, 1, 32'h1, 0, 0, 32'hDEAD_BEEF);
      checks++;
      if (obs_rd !== 32'hDEAD_BEEF || obs_wren !== 1'b1) begin
         errors++; $display("FAIL dmem_store: got rd=%h wren=%b expected deadbeef 1", obs_rd, obs_wren);
      end
      step(0, 100, 0, 0, 0, 0, 32'hDEAD_BEEF);
      checks++;
      if (obs_rd !== 32'hDEAD_BEEF || obs_wren !== 1'b0) begin
         errors++; $display("FAIL dmem_load: got rd=%h wren=%b expected deadbeef 0", obs_rd, obs_wren);
      end
   endtask

   task automatic test_keyboard;
      step(1, 0, 0, 0, 0, 0, 0);
      push_code(8'h1C); push_code(8'h23); push_code(8'h1D);
`ifdef MMIO_KBD_FIFO_EN
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h11C) begin
         errors++; $display("FAIL kbd_head: got %h expected 0000011c", obs_rd);
      end
      step(0, STAT, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h06) begin
         errors++; $display("FAIL kbd_stat3: got %h expected 00000006", obs_rd);
      end
      step(0, KBD, 1, 0, 0, 0, 0);
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h123) begin
         errors++; $display("FAIL kbd_pop: got %h expected 00000123", obs_rd);
      end
      // fill past depth
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) push_code(8'(8'h30 + i));
      step(0, STAT, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h11) begin
         errors++; $display("FAIL kbd_overflow: got %h expected 00000011", obs_rd);
      end
      step(0, STAT, 1, 0, 0, 0, 0);
      step(0, STAT, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h10) begin
         errors++; $display("FAIL kbd_ovf_clear: got %h expected 00000010", obs_rd);
      end
      step(0, KBD, 1, 0, 1, 8'h77, 0);
      step(0, STAT, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h10) begin
         errors++; $display("FAIL kbd_full_push_pop: got %h expected 00000010", obs_rd);
      end
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h131) begin
         errors++; $display("FAIL kbd_head_after_wrap: got %h expected 00000131", obs_rd);
      end
      // push and pop together on an empty FIFO
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, KBD, 1, 0, 1, 8'h42, 0);
      step(0, STAT, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h02) begin
         errors++; $display("FAIL kbd_empty_push_pop: got %h expected 00000002", obs_rd);
      end
`else
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h1D) begin
         errors++; $display("FAIL kbd_last_code: got %h expected 0000001d", obs_rd);
      end
      step(0, KBD, 1, 0, 0, 0, 0);
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h1D) begin
         errors++; $display("FAIL kbd_store_ignored: got %h expected 0000001d", obs_rd);
      end
      step(0, STAT, 0, 0, 0, 0, 32'h5A5A);
      checks++;
      if (obs_rd !== 32'd0) begin
         errors++; $display("FAIL kbd_stat_zero: got %h expected 0", obs_rd);
      end
`endif
   endtask

   task automatic test_hold_strobe;
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'(8'h2A + i), 0);
      step(0, 0, 0, 0, 0, 0, 0);
`ifdef MMIO_KBD_FIFO_EN
      step(0, STAT, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h02) begin
         errors++; $display("FAIL hold_one_push: got %h expected 00000002", obs_rd);
      end
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h12A) begin
         errors++; $display("FAIL hold_code: got %h expected 0000012a", obs_rd);
      end
`else
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'h2A) begin
         errors++; $display("FAIL hold_code: got %h expected 0000002a", obs_rd);
      end
`endif
   endtask

   task automatic test_reset_mid;
      push_code(8'h11); push_code(8'h22); push_code(8'h33);
      step(0, PBASE + 4, 1, 32'h1234, 0, 0, 0);
      step(1, PBASE + 4, 1, 32'h9999, 0, 0, 0);
      step(0, KBD, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'd0) begin
         errors++; $display("FAIL reset_mid_kbd: got %h expected 0", obs_rd);
      end
      step(0, PBASE + 4, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rd !== 32'd240) begin
         errors++; $display("FAIL reset_mid_player: got %h expected 000000f0", obs_rd);
      end
   endtask

   task automatic test_random;
      int addr;
      logic kp;
      logic [3:0] sel;
      kp = 0;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1:       addr = KBD;
            2:          addr = STAT;
            3, 4, 5, 6: addr = PBASE + int'($urandom_range(0, 4 * NP - 1));
            default:    addr = int'($urandom_range(0, 4095));
         endcase
         if ($urandom_range(0, 9) < 3) kp = ~kp;
         step(($urandom_range(0, 63) == 0), addr, ($urandom_range(0, 9) < 4), $urandom,
              kp, 8'($urandom), $urandom);
         checks++;
         if (obs_rd !== exp_rd) begin
            errors++; $display("FAIL rand_read @%0d: got %h expected %h", addr % 4096, obs_rd, exp_rd);
         end
         checks++;
         if (obs_wren !== exp_wren) begin
            errors++; $display("FAIL rand_dmem_wren @%0d: got %b expected %b", addr % 4096, obs_wren, exp_wren);
         end
         if (n % 8 == 7) begin
            @(negedge clock);
            sel = 4'($urandom_range(0, 15));
            vga_player_sel = sel; #1;
            checks++;
            if (int'(sel) < NP) begin
               if (vga_player_x !== m_x[sel] || vga_player_y !== m_y[sel]) begin
                  errors++; $display("FAIL rand_vga sel=%0d: got %h/%h expected %h/%h",
                                     sel, vga_player_x, vga_player_y, m_x[sel], m_y[sel]);
               end
            end else if (vga_player_x !== 32'd0 || vga_player_y !== 32'd0) begin
               errors++; $display("FAIL rand_vga sel=%0d: got %h/%h expected 0/0",
                                  sel, vga_player_x, vga_player_y);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; address_dmem = '0; proc_data_out = '0; wren = 1'b0;
      dmem_q = '0; ps2_key_pressed = 1'b0; ps2_out = '0; vga_player_sel = '0;
      test_reset;
      test_player_store;
      test_same_cycle_rw;
      test_dmem_passthrough;
      test_keyboard;
      test_hold_strobe;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
